viterbi_ber_checker: RTL and testbench

Bit-error-rate monitor that sits directly downstream of the Viterbi decoder in the tx/rx loop. It buffers each source bit fed to the convolutional encoder and compares it, in order, against each bit the decoder produces. It counts compared bits, residual errors and the longest run of consecutive errors, so injected-error patterns can be scored in hardware rather than by simulation printouts.

---
 rtl/viterbi_pkg.sv | 16 +
 rtl/viterbi_bit_fifo.sv | 58 +++++
 rtl/viterbi_ber_checker.sv | 155 +++++++++++++++
 tb/tb_viterbi_ber_checker.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// viterbi_pkg
//   Shared types and constants for the Viterbi BER checker slice.
//   chk_state_t : checker run state (IDLE, SKIP, RUN, DONE)
//   CNT_W_DEF   : default width of the bit/error/burst counters
package viterbi_pkg;

   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SKIP = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } chk_state_t;

endpackage

// File: rtl/viterbi_bit_fifo.sv
// viterbi_bit_fifo
//   Single-bit FIFO holding the reference (source) bits until the decoder
//   produces the matching output bit.
//   Ports:
//     clk, rst   clock, asynchronous active-low reset (pointers only)
//     flush      empty the FIFO next cycle; push/pop ignored this cycle
//     push, din  write din at the tail
//     pop        advance the head
//     dout       current head bit (valid while !empty)
//     full/empty occupancy flags
//   The caller qualifies push/pop: it never pushes into a full FIFO without
//   a simultaneous pop, and never pops an empty FIFO.
module viterbi_bit_fifo #(
   parameter int DEPTH = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic push,
   input  logic pop,
   input  logic din,
   output logic dout,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit distinguishes full from empty when the
   // address bits are equal.
   logic [AW:0] wr_ptr_reg;
   logic [AW:0] rd_ptr_reg;
   logic        mem [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr_reg[AW-1:0]] <= din;
   end

   // Head is read combinationally so the compare happens in the pop cycle.
   assign dout  = mem[rd_ptr_reg[AW-1:0]];
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/viterbi_ber_checker.sv
// viterbi_ber_checker
//   Bit-error-rate monitor placed after the Viterbi decoder. Source bits are
//   buffered in a FIFO and compared in order against decoded bits.
//   Ports:
//     clk, rst         clock, asynchronous active-low reset
//     start_i          pulse: clear counters/flags, flush FIFO, begin run
//     src_bit_i/valid  reference bit push
//     dec_bit_i/valid  decoded bit pop + compare
//     bit_cnt_o        bits compared this run (saturating)
//     err_cnt_o        mismatches this run (saturating)
//     max_burst_o      longest run of consecutive mismatches
//     busy_o, done_o   run active / run complete (counters frozen)
//     ovf_o, unf_o     sticky push-while-full / pop-while-empty
module viterbi_ber_checker
   import viterbi_pkg::*;
#(
   parameter int DEPTH     = 64,
   parameter int CNT_W     = CNT_W_DEF,
   parameter int NUM_BITS  = 256,
   parameter int SKIP_BITS = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             src_bit_i,
   input  logic             src_valid_i,
   input  logic             dec_bit_i,
   input  logic             dec_valid_i,
   output logic [CNT_W-1:0] bit_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic [CNT_W-1:0] max_burst_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             ovf_o,
   output logic             unf_o
);

   localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(SKIP_BITS);

   chk_state_t       state_reg, state_next;
   logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
   logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;
   logic [CNT_W-1:0] max_burst_reg, max_burst_next;
   logic [CNT_W-1:0] cur_burst_reg, cur_burst_next;
   logic [CNT_W-1:0] skip_cnt_reg, skip_cnt_next;
   logic             ovf_reg, ovf_next;
   logic             unf_reg, unf_next;

   logic             active;
   logic             fifo_push, fifo_pop, fifo_head, fifo_full, fifo_empty;
   logic             compare, mismatch;
   logic [CNT_W-1:0] bit_cnt_inc, err_cnt_inc, cur_burst_inc, skip_cnt_inc;

   // FIFO traffic only while a run is in progress, and never in a start cycle.
   assign active    = ((state_reg == SKIP) || (state_reg == RUN)) && !start_i;
   assign fifo_pop  = active && dec_valid_i && !fifo_empty;
   // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
   assign fifo_push = active && src_valid_i && (!fifo_full || fifo_pop);
   assign compare   = fifo_pop && (state_reg == RUN);
   assign mismatch  = fifo_head ^ dec_bit_i;

   // Saturating increments: counters stick at all-ones instead of wrapping.
   assign bit_cnt_inc   = (&bit_cnt_reg)   ? bit_cnt_reg   : bit_cnt_reg + 1'b1;
   assign err_cnt_inc   = (&err_cnt_reg)   ? err_cnt_reg   : err_cnt_reg + 1'b1;
   assign cur_burst_inc = (&cur_burst_reg) ? cur_burst_reg : cur_burst_reg + 1'b1;
   assign skip_cnt_inc  = (&skip_cnt_reg)  ? skip_cnt_reg  : skip_cnt_reg + 1'b1;

   viterbi_bit_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (start_i),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (src_bit_i),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         bit_cnt_reg   <= '0;
         err_cnt_reg   <= '0;
         max_burst_reg <= '0;
         cur_burst_reg <= '0;
         skip_cnt_reg  <= '0;
         ovf_reg       <= 1'b0;
         unf_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         bit_cnt_reg   <= bit_cnt_next;
         err_cnt_reg   <= err_cnt_next;
         max_burst_reg <= max_burst_next;
         cur_burst_reg <= cur_burst_next;
         skip_cnt_reg  <= skip_cnt_next;
         ovf_reg       <= ovf_next;
         unf_reg       <= unf_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      bit_cnt_next   = bit_cnt_reg;
      err_cnt_next   = err_cnt_reg;
      max_burst_next = max_burst_reg;
      cur_burst_next = cur_burst_reg;
      skip_cnt_next  = skip_cnt_reg;
      ovf_next       = ovf_reg;
      unf_next       = unf_reg;

      if (start_i) begin
         state_next     = (SKIP_BITS > 0) ? SKIP : RUN;
         bit_cnt_next   = '0;
         err_cnt_next   = '0;
         max_burst_next = '0;
         cur_burst_next = '0;
         skip_cnt_next  = '0;
         ovf_next       = 1'b0;
         unf_next       = 1'b0;
      end else begin
         if (active && src_valid_i && fifo_full && !fifo_pop) ovf_next = 1'b1;
         if (active && dec_valid_i && fifo_empty)             unf_next = 1'b1;

         // Traceback warm-up: discard decoded bits without scoring them.
         if (fifo_pop && (state_reg == SKIP)) begin
            skip_cnt_next = skip_cnt_inc;
            if (skip_cnt_inc == SKIP_LAST) state_next = RUN;
         end

         if (compare) begin
            bit_cnt_next = bit_cnt_inc;
            if (mismatch) begin
               err_cnt_next   = err_cnt_inc;
               cur_burst_next = cur_burst_inc;
               if (cur_burst_inc > max_burst_reg) max_burst_next = cur_burst_inc;
            end else begin
               cur_burst_next = '0;
            end
            if (32'(bit_cnt_inc) == 32'(NUM_BITS)) state_next = DONE;
         end
      end
   end

   assign bit_cnt_o   = bit_cnt_reg;
   assign err_cnt_o   = err_cnt_reg;
   assign max_burst_o = max_burst_reg;
   assign busy_o      = (state_reg == SKIP) || (state_reg == RUN);
   assign done_o      = (state_reg == DONE);
   assign ovf_o       = ovf_reg;
   assign unf_o       = unf_reg;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// tb_viterbi_ber_checker
//   Drives three checker instances with one shared stimulus stream:
//     u0: defaults (SKIP_BITS=0, CNT_W=16), u1: SKIP_BITS=8, u2: CNT_W=4.
//   Each instance is compared every cycle against a queue-based model of
//   the measurement rules, plus fixed expected numbers for key scenarios.
module tb_viterbi_ber_checker;

   localparam int NB    = 256;
   localparam int DEPTH = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst         = 1'b0;
   logic start_i     = 1'b0;
   logic src_bit_i   = 1'b0;
   logic src_valid_i = 1'b0;
   logic dec_bit_i   = 1'b0;
   logic dec_valid_i = 1'b0;

   logic [15:0] bc0, ec0, mb0, bc1, ec1, mb1;
   logic [3:0]  bc2, ec2, mb2;
   logic        busy0, done0, ovf0, unf0;
   logic        busy1, done1, ovf1, unf1;
   logic        busy2, done2, ovf2, unf2;

   viterbi_ber_checker #(.DEPTH(DEPTH), .CNT_W(16), .NUM_BITS(NB), .SKIP_BITS(0)) u0 (
      .clk(clk), .rst(rst), .start_i(start_i), .src_bit_i(src_bit_i),
      .src_valid_i(src_valid_i), .dec_bit_i(dec_bit_i), .dec_valid_i(dec_valid_i),
      .bit_cnt_o(bc0), .err_cnt_o(ec0), .max_burst_o(mb0),
      .busy_o(busy0), .done_o(done0), .ovf_o(ovf0), .unf_o(unf0));

   viterbi_ber_checker #(.DEPTH(DEPTH), .CNT_W(16), .NUM_BITS(NB), .SKIP_BITS(8)) u1 (
      .clk(clk), .rst(rst), .start_i(start_i), .src_bit_i(src_bit_i),
      .src_valid_i(src_valid_i), .dec_bit_i(dec_bit_i), .dec_valid_i(dec_valid_i),
      .bit_cnt_o(bc1), .err_cnt_o(ec1), .max_burst_o(mb1),
      .busy_o(busy1), .done_o(done1), .ovf_o(ovf1), .unf_o(unf1));

   viterbi_ber_checker #(.DEPTH(DEPTH), .CNT_W(4), .NUM_BITS(NB), .SKIP_BITS(0)) u2 (
      .clk(clk), .rst(rst), .start_i(start_i), .src_bit_i(src_bit_i),
      .src_valid_i(src_valid_i), .dec_bit_i(dec_bit_i), .dec_valid_i(dec_valid_i),
      .bit_cnt_o(bc2), .err_cnt_o(ec2), .max_burst_o(mb2),
      .busy_o(busy2), .done_o(done2), .ovf_o(ovf2), .unf_o(unf2));

   // Observed outputs per instance: bit, err, burst, busy, done, ovf, unf.
   int obs [3][7];
   always_comb begin
      obs[0][0] = 32'(bc0); obs[0][1] = 32'(ec0); obs[0][2] = 32'(mb0);
      obs[0][3] = 32'(busy0); obs[0][4] = 32'(done0); obs[0][5] = 32'(ovf0); obs[0][6] = 32'(unf0);
      obs[1][0] = 32'(bc1); obs[1][1] = 32'(ec1); obs[1][2] = 32'(mb1);
      obs[1][3] = 32'(busy1); obs[1][4] = 32'(done1); obs[1][5] = 32'(ovf1); obs[1][6] = 32'(unf1);
      obs[2][0] = 32'(bc2); obs[2][1] = 32'(ec2); obs[2][2] = 32'(mb2);
      obs[2][3] = 32'(busy2); obs[2][4] = 32'(done2); obs[2][5] = 32'(ovf2); obs[2][6] = 32'(unf2);
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int p_skip [3] = '{0, 8, 0};
   int p_w    [3] = '{16, 16, 4};

   int m_act [3], m_done [3], m_ovf [3], m_unf [3];
   int m_cmp [3], m_err [3], m_burst [3], m_max [3], m_skip_left [3];
   bit q0 [$];
   bit q1 [$];
   bit q2 [$];

   function automatic int sat(input int id);
      return (1 << p_w[id]) - 1;
   endfunction

   function automatic int clip(input int v, input int id);
      return (v > sat(id)) ? sat(id) : v;
   endfunction

   function automatic int qsize(input int id);
      case (id)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic qpush(input int id, input bit b);
      case (id)
         0:       q0.push_back(b);
         1:       q1.push_back(b);
         default: q2.push_back(b);
      endcase
   endtask

   task automatic qpop(input int id, output bit b);
      case (id)
         0:       b = q0.pop_front();
         1:       b = q1.pop_front();
         default: b = q2.pop_front();
      endcase
   endtask

   task automatic model_clear(input int id);
      m_done[id] = 0; m_ovf[id] = 0; m_unf[id] = 0;
      m_cmp[id] = 0; m_err[id] = 0; m_burst[id] = 0; m_max[id] = 0;
      m_skip_left[id] = p_skip[id];
      case (id)
         0:       q0.delete();
         1:       q1.delete();
         default: q2.delete();
      endcase
   endtask

   // One clock edge of measurement rules for instance id, on current inputs.
   task automatic model_step(input int id);
      bit popped, head;
      int n;
      if (start_i) begin
         model_clear(id);
         m_act[id] = 1;
         return;
      end
      if (m_act[id] == 0) return;
      n      = qsize(id);
      popped = dec_valid_i && (n > 0);
      head   = 1'b0;
      if (dec_valid_i && n == 0) m_unf[id] = 1;
      if (popped) qpop(id, head);
      if (src_valid_i) begin
         if (n == DEPTH && !popped) m_ovf[id] = 1;
         else qpush(id, src_bit_i);
      end
      if (popped) begin
         if (m_skip_left[id] > 0) begin
            m_skip_left[id]--;
         end else begin
            m_cmp[id]++;
            if (head != dec_bit_i) begin
               m_err[id]++;
               m_burst[id]++;
               if (m_burst[id] > m_max[id]) m_max[id] = m_burst[id];
            end else begin
               m_burst[id] = 0;
            end
            // The visible (saturated) count must be able to reach NB.
            if (m_cmp[id] == NB && NB <= sat(id)) begin
               m_done[id] = 1;
               m_act[id]  = 0;
            end
         end
      end
   endtask

   task automatic check_all(input string ph);
      for (int id = 0; id < 3; id++) begin
         chk($sformatf("%s/u%0d bit_cnt", ph, id),   obs[id][0], clip(m_cmp[id], id));
         chk($sformatf("%s/u%0d err_cnt", ph, id),   obs[id][1], clip(m_err[id], id));
         chk($sformatf("%s/u%0d max_burst", ph, id), obs[id][2], clip(m_max[id], id));
         chk($sformatf("%s/u%0d busy", ph, id),      obs[id][3], m_act[id]);
         chk($sformatf("%s/u%0d done", ph, id),      obs[id][4], m_done[id]);
         chk($sformatf("%s/u%0d ovf", ph, id),       obs[id][5], m_ovf[id]);
         chk($sformatf("%s/u%0d unf", ph, id),       obs[id][6], m_unf[id]);
      end
   endtask

   task automatic drive(input logic st, input logic sv, input logic sb,
                        input logic dv, input logic db);
      start_i = st; src_valid_i = sv; src_bit_i = sb;
      dec_valid_i = dv; dec_bit_i = db;
   endtask

   task automatic step(input string ph);
      @(posedge clk);
      for (int id = 0; id < 3; id++) model_step(id);
      #1;
      check_all(ph);
   endtask

   function automatic bit flip(input int mode, input int k);
      case (mode)
         1:       return ((k % 32) >= 10) && ((k % 32) <= 13);
         2:       return k < 8;
         3:       return 1'b1;
         4:       return (k == 3) || (k == 7) || (k == 20) || (k == 50) || (k == 90);
         default: return 1'b0;
      endcase
   endfunction

   // Decoder echoes the source stream with 20-cycle latency, with an error
   // pattern applied by decoded-bit index.
   task automatic run_echo(input int mode, input int restart_at, input string ph);
      bit hist [320];
      bit b, dbb;
      logic dvv;
      drive(1, 0, 0, 0, 0);
      step(ph);
      for (int t = 0; t < 320; t++) begin
         if (t == restart_at) begin
            chk({ph, " pre-restart bit_cnt"}, 32'(bc0), 100);
            chk({ph, " pre-restart err_cnt"}, 32'(ec0), 5);
            drive(1, 1, 1, 1, 0);
            step(ph);
            chk({ph, " restart bit_cnt"}, 32'(bc0), 0);
            chk({ph, " restart err_cnt"}, 32'(ec0), 0);
            chk({ph, " restart busy"}, 32'(busy0), 1);
            drive(0, 0, 0, 1, 0);
            step(ph);
            chk({ph, " restart fifo empty"}, 32'(unf0), 1);
            return;
         end
         b       = 1'($urandom % 2);
         hist[t] = b;
         dvv     = (t >= 20);
         dbb     = dvv ? (hist[t-20] ^ flip(mode, t - 20)) : 1'b0;
         drive(0, t < 300, b, dvv, dbb);
         step(ph);
      end
      drive(0, 0, 0, 0, 0);
      step(ph);
      $display("run %s: u0 bit=%0d err=%0d burst=%0d done=%0d | u1 bit=%0d err=%0d | u2 err=%0d",
               ph, bc0, ec0, mb0, done0, bc1, ec1, ec2);
   endtask

   initial begin
      bit tq [$];
      bit sb, db;
      logic sv, dv;

      for (int id = 0; id < 3; id++) begin
         m_act[id] = 0;
         model_clear(id);
      end

      #12;
      check_all("reset");
      $display("run reset: u0 bit=%0d busy=%0d done=%0d", bc0, busy0, done0);
      rst = 1'b1;

      // IDLE ignores valids.
      drive(0, 1, 1, 1, 0);
      step("idle");
      drive(0, 0, 0, 0, 0);
      step("idle");

      // Underflow then overflow, both sticky.
      drive(1, 0, 0, 0, 0);
      step("flags");
      drive(0, 0, 0, 1, 1);
      step("flags");
      chk("unf set", 32'(unf0), 1);
      chk("unf bit_cnt", 32'(bc0), 0);
      for (int i = 0; i < DEPTH + 1; i++) begin
         drive(0, 1, 1'($urandom % 2), 0, 0);
         step("flags");
      end
      chk("ovf set", 32'(ovf0), 1);
      drive(0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step("flags");
      chk("ovf sticky", 32'(ovf0), 1);
      chk("unf sticky", 32'(unf0), 1);
      $display("run flags: u0 ovf=%0d unf=%0d bit=%0d", ovf0, unf0, bc0);

      run_echo(0, -1, "clean");
      chk("clean bit_cnt", 32'(bc0), 256);
      chk("clean err_cnt", 32'(ec0), 0);
      chk("clean max_burst", 32'(mb0), 0);
      chk("clean done", 32'(done0), 1);
      chk("clean skip bit_cnt", 32'(bc1), 256);
      chk("clean sat bit_cnt", 32'(bc2), 15);

      run_echo(1, -1, "burst");
      chk("burst err_cnt", 32'(ec0), 32);
      chk("burst max_burst", 32'(mb0), 4);
      chk("burst bit_cnt", 32'(bc0), 256);
      chk("burst skip err_cnt", 32'(ec1), 32);

      run_echo(2, -1, "skip");
      chk("skip err_cnt", 32'(ec1), 0);
      chk("skip bit_cnt", 32'(bc1), 256);
      chk("skip u0 err_cnt", 32'(ec0), 8);

      run_echo(3, -1, "inverted");
      chk("sat err_cnt", 32'(ec2), 15);
      chk("sat max_burst", 32'(mb2), 15);
      chk("inverted err_cnt", 32'(ec0), 256);

      run_echo(4, 120, "restart");

      // Random traffic; asynchronous reset asserted mid-run.
      drive(1, 0, 0, 0, 0);
      step("random");
      for (int c = 0; c < 900; c++) begin
         if (c == 450) begin
            #3 rst = 1'b0;
            #1;
            for (int id = 0; id < 3; id++) begin
               m_act[id] = 0;
               model_clear(id);
            end
            chk("async rst bit_cnt", 32'(bc0), 0);
            chk("async rst busy", 32'(busy0), 0);
            check_all("async_rst");
            @(posedge clk);
            #4 rst = 1'b1;
            $display("run async_rst: u0 bit=%0d busy=%0d", bc0, busy0);
            tq.delete();
            drive(1, 0, 0, 0, 0);
            step("random");
         end
         sv = ($urandom % 2) == 0;
         dv = ($urandom % 5) < 2;
         sb = 1'($urandom % 2);
         db = 1'($urandom % 2);
         if (dv && tq.size() > 0) db = tq.pop_front() ^ (($urandom % 10) == 0);
         if (sv && tq.size() < DEPTH) tq.push_back(sb);
         drive(0, sv, sb, dv, db);
         step("random");
      end
      $display("run random: u0 bit=%0d err=%0d burst=%0d ovf=%0d unf=%0d", bc0, ec0, mb0, ovf0, unf0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
